// File: rtl/noc_params.sv
// Shared NoC router definitions: framing bytes, scheduler states,
// packet layout and the byte-stuffing predicate.
package noc_params;

    localparam logic [7:0] FLAG      = 8'h7E;
    localparam logic [7:0] ESC       = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    localparam int DEF_DATA_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_BODY,
        ST_ESC,
        ST_EOF
    } sched_state_t;

    typedef struct packed {
        logic [7:0]                  dest;
        logic [8*DEF_DATA_BYTES-1:0] data;
    } packet_t;

    // A byte that collides with a framing byte must be stuffed
    function automatic logic needs_escape(input logic [7:0] b);
        return (b == FLAG) || (b == ESC);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the priority pointer lives in
// the parent so the same block can be reused for pe_link sharing.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic found;

    // First requester found searching upward from last_grant+1
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (enable && !found
                && req[(int'(last_grant) + off) % N]) begin
                found = 1'b1;
                grant[(int'(last_grant) + off) % N] = 1'b1;
                idx = IW'((int'(last_grant) + off) % N);
            end
        end
    end

endmodule

// File: rtl/out_port_scheduler.sv
// Output port scheduler: round-robin grant of whole packets and
// serialization as flag-delimited, byte-stuffed frames.
module out_port_scheduler
    import noc_params::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BYTES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0][7:0]               req_dest,
    input  logic [NUM_REQ-1:0][8*DATA_BYTES-1:0]  req_data,
    output logic [NUM_REQ-1:0]                    req_ack,
    output logic [7:0]                            out_byte,
    output logic                                  busy,
    output logic [$clog2(NUM_REQ)-1:0]            grant_id
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int SRW = 8 * (1 + DATA_BYTES);
    localparam int CW  = $clog2(DATA_BYTES + 1);

    sched_state_t       state_q, state_d;
    logic [SRW-1:0]     sr_q, sr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               esc_q, esc_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      gid_q, gid_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         out_q, out_d;
    logic               busy_q;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gidx;
    logic [7:0]         cur;
    logic               adv;

    sched_state_t       step_state;
    logic [7:0]         step_out;
    logic               step_adv;
    logic               step_esc;

    assign cur = sr_q[SRW-1 -: 8];

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .enable     (state_q == ST_IDLE),
        .grant      (grant),
        .idx        (gidx)
    );

    // Next body action: EOF when all bytes are out, else byte or escape
    always_comb begin
        step_state = ST_BODY;
        step_out   = cur;
        step_adv   = 1'b0;
        step_esc   = 1'b0;
        if (done_q) begin
            step_state = ST_EOF;
            step_out   = FLAG;
        end else if (needs_escape(cur)) begin
            step_out = ESC;
            step_esc = 1'b1;
        end else begin
            step_adv = 1'b1;
        end
    end

    // Frame FSM next state; out_d is the byte shown in the next state
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        esc_d   = 1'b0;
        last_d  = last_q;
        gid_d   = gid_q;
        ack_d   = '0;
        out_d   = IDLE_BYTE;
        adv     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    state_d = ST_SOF;
                    out_d   = FLAG;
                    sr_d    = {req_dest[gidx], req_data[gidx]};
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    last_d  = gidx;
                    gid_d   = gidx;
                    ack_d   = grant;
                end
            end
            ST_SOF, ST_ESC: begin
                state_d = step_state;
                out_d   = step_out;
                esc_d   = step_esc;
                adv     = step_adv;
            end
            ST_BODY: begin
                if (esc_q) begin
                    state_d = ST_ESC;
                    out_d   = cur ^ ESC_XOR;
                    adv     = 1'b1;
                end else begin
                    state_d = step_state;
                    out_d   = step_out;
                    esc_d   = step_esc;
                    adv     = step_adv;
                end
            end
            ST_EOF: begin
                state_d = ST_IDLE;
                out_d   = IDLE_BYTE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (adv) begin
            sr_d = {sr_q[SRW-9:0], 8'h00};
            if (cnt_q == CW'(DATA_BYTES)) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, datapath and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            esc_q   <= 1'b0;
            last_q  <= IW'(NUM_REQ - 1);
            gid_q   <= '0;
            ack_q   <= '0;
            out_q   <= IDLE_BYTE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            esc_q   <= esc_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            out_q   <= out_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign req_ack  = ack_q;
    assign out_byte = out_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: doc/out_port_scheduler.md
# out_port_scheduler

Per-output-port scheduler for the NoC router. It shares one 8-bit output byte stream among NUM_REQ requesters, which are the deframed packet buffers of the input ports and the PE. Each requester offers one packet: an 8-bit destination and a 32-bit payload. The scheduler grants requesters round-robin and holds each grant for a whole frame. It then serializes the packet as a flag-delimited, byte-stuffed frame onto `out_byte`.

## Interface
Parameters:
- NUM_REQ, default 4, number of requesters.
- DATA_BYTES, default 4, payload bytes per packet; the payload width is 8*DATA_BYTES.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a packet; held high until acked.
- req_dest  in  NUM_REQ x 8  destination byte per requester.
- req_data  in  NUM_REQ x 8*DATA_BYTES  payload per requester; MSB byte is sent first.
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse; the packet was captured.
- out_byte  out  8  registered output byte stream.
- busy  out  1  high while a frame is being emitted (state is not IDLE).
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- States: IDLE, SOF, BODY, ESC, EOF.
- IDLE:
  - out_byte = 0x00.
  - If any req_valid is high, pick the first set bit searching upward from (last_grant+1) mod NUM_REQ.
  - Capture the picked requester's {dest, data} into a shift register of (1+DATA_BYTES) bytes.
  - Pulse req_ack for that requester, update last_grant and grant_id, and go to SOF.
- SOF: emit 0x7E; then go to BODY.
- BODY: take the current byte b.
  - If b is 0x7E or 0x7D: emit 0x7D and go to ESC.
  - Otherwise: emit b and advance the byte counter.
  - After the last byte is consumed, go to EOF.
- ESC: emit b ^ 0x20, advance the byte counter, and return to BODY, or go to EOF if b was the last byte.
- EOF: emit 0x7E; then go to IDLE. IDLE always emits at least one 0x00 before the next SOF.
- req_valid is ignored outside IDLE, and req_ack stays low outside IDLE.
- The requester may change dest/data, or present its next packet, in the cycle after the ack.
- The byte counter counts 0..DATA_BYTES. Wrap is not possible because the counter resets to 0 on each grant.

## Timing
- Reset values:
  - out_byte = 0x00, req_ack = 0, busy = 0, grant_id = 0.
  - state = IDLE, last_grant = NUM_REQ-1, so requester 0 has first priority.
- The grant is decided combinationally from req_valid in cycle k. The capture and req_ack pulse occur in cycle k (the ack is registered out at edge k+1 together with out_byte = 0x7E).
- Frame length is 2 + (1+DATA_BYTES) + E cycles, where E is the number of escaped bytes.
  - Minimum with DATA_BYTES=4: 7 cycles plus 1 idle cycle, so 8 cycles per packet back-to-back.
- busy is high exactly for the cycles out_byte carries a frame byte.
- Simultaneous requests are resolved only by the round-robin pointer. Requesters that are not granted remain pending with no ack.
- Reset mid-frame:
  - Next cycle: IDLE, out_byte = 0x00, pointer reinitialized.
  - The partial frame is truncated without EOF. The already-acked packet is dropped and not re-acked.

## Structure
- The shared package noc_params holds:
  - constants FLAG = 8'h7E, ESC = 8'h7D, ESC_XOR = 8'h20, IDLE_BYTE = 8'h00;
  - typedef sched_state_t (IDLE, SOF, BODY, ESC, EOF);
  - the packet typedef {dest, data}.
- Sub-module rr_arbiter (parameter N): inputs req[N], last_grant, enable; outputs one-hot grant and index. It is purely combinational with the pointer register in the parent; the arbiter is reusable for pe_link sharing.
- The parent holds the FSM, shift register, byte counter, and the output register.

## Test plan
- Single packet: req_valid[0] with dest 0x11, data 0x11111111 -> out_byte is 7E 11 11 11 11 11 7E 00, and req_ack[0] pulses once in the capture cycle.
- Escaping: dest 0x7E, data 0x7D440000 on requester 2 -> out_byte is 7E 7D 5E 7D 5D 44 00 00 7E 00, and busy is high for exactly 9 cycles.
- Round-robin: all four valid from reset with distinct data 0x11111111/0x22222222/0x33333333/0x44444444 -> frames appear in order 0,1,2,3, each separated by exactly one 0x00. grant_id follows 0,1,2,3.
- Fairness:
  - Setup: after requester 2 is served, only requesters 0 and 3 are valid.
  - Required response: requester 3 is granted before 0.
  - Then, with requester 1 asserting mid-frame: no ack to 1 until the frame ends.
- Reset mid-frame: assert rst during the third BODY byte -> the next cycle shows out_byte 0x00, busy 0, and no EOF. A subsequent request from requester 0 is granted first.
